// File: rtl/coeff_pkg.sv
// Shared definitions for the prestep coefficient load sequencer:
// default sizes, FSM state encoding and the tap-enable mask helper.
package coeff_pkg;

  localparam int unsigned BITS_DEF   = 32;
  localparam int unsigned CGES_DEF   = 49;
  localparam int unsigned ADDR_W_DEF = $clog2(CGES_DEF);
  localparam int unsigned NUM_W_DEF  = $clog2(CGES_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Bit i of the thermometer mask for n loaded taps; tap 0 is always enabled.
  // Evaluated per bit so the mask width follows the instance's CGES.
  function automatic logic therm_mask_bit(input int unsigned i, input int unsigned n);
    return (i == 0) || (i < n);
  endfunction

endpackage

// File: rtl/coeff_load_ctrl.sv
// Write-side sequencer for the prestep coefficient bank: streams host
// coefficients into the bank, zero-fills unused taps, then commits the mask.
module coeff_load_ctrl
  import coeff_pkg::*;
#(
  parameter int unsigned BITS   = BITS_DEF,
  parameter int unsigned CGES   = CGES_DEF,
  parameter int unsigned ADDR_W = $clog2(CGES),
  parameter int unsigned NUM_W  = $clog2(CGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUM_W-1:0]  num_taps,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BITS-1:0]   s_data,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [BITS-1:0]   value,
  output logic [CGES-1:0]   cges,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]    n_q, n_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BITS-1:0]     value_q, value_d;
  logic [CGES-1:0]     cges_q, cges_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                start_bad;
  logic                last_beat;
  logic                last_fill;

  assign start_bad = (num_taps == '0) || (num_taps > NUM_W'(CGES));
  assign last_beat = (NUM_W'(cnt_q) == (n_q - NUM_W'(1)));
  assign last_fill = (cnt_q == ADDR_W'(CGES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    value_d = value_q;
    cges_d  = cges_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            n_d     = num_taps;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        // abort masks s_ready, so no beat can land in the abort cycle
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          wen_d   = 1'b1;
          addr_d  = cnt_q;
          value_d = s_data;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (last_beat) begin
            state_d = (n_q == NUM_W'(CGES)) ? COMMIT : FILL;
          end
        end
      end

      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          wen_d   = 1'b1;
          addr_d  = cnt_q;
          value_d = '0;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (last_fill) begin
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        for (int unsigned i = 0; i < CGES; i++) begin
          cges_d[i] = therm_mask_bit(i, 32'(n_q));
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      cges_q  <= {{(CGES - 1){1'b0}}, 1'b1};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      cges_q  <= cges_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready = (state_q == LOAD) && !abort;
  assign busy    = (state_q != IDLE);
  assign wen     = wen_q;
  assign addr    = addr_q;
  assign value   = value_q;
  assign cges    = cges_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/coeff_load_ctrl.md
Name: coeff_load_ctrl

Overview:
Write-side sequencer for the prestep coefficient register bank. It accepts a stream of filter coefficients from a host over a valid/ready handshake and issues one register write per coefficient on the bank's write port (wen/addr/value). After loading it zero-fills the unused taps, then commits the tap-enable mask (cges) atomically. Sits between the host/config interface and the prestep coefficient bank.

Parameters:
BITS, 32, coefficient width; equals value width of the bank.
CGES, 49, number of coefficient registers (taps).
ADDR_W, $clog2(CGES), width of the write address.
NUM_W, $clog2(CGES+1), width of the tap-count input.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
num_taps  in  NUM_W  number of coefficients to load; legal range 1..CGES; sampled with start.
abort  in  1  cancel an in-progress load.
s_valid  in  1  host coefficient valid.
s_ready  out  1  controller can accept a coefficient.
s_data  in  BITS  coefficient value.
wen  out  1  write enable to the bank; one-cycle pulse per write.
addr  out  ADDR_W  write address to the bank.
value  out  BITS  write data to the bank.
cges  out  CGES  committed tap-enable mask.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse when a load commits.
err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, cnt=0, n=0, wen=0, addr=0, value=0, done=0, err=0, cges={CGES-1{0},1}. s_ready and busy decode to 0. Reset mid-load abandons the load; no done.
- All of wen, addr, value, cges, done and err are registered. s_ready = (state==LOAD) && !abort. busy = (state!=IDLE).
- FSM states: IDLE, LOAD, FILL, COMMIT.
- IDLE: on start with 1<=num_taps<=CGES: latch n=num_taps, set cnt=0, go to LOAD. On start with num_taps==0 or num_taps>CGES: err=1 for the next cycle, stay IDLE, cges unchanged. start is ignored in every other state.
- LOAD: a beat is accepted when s_valid&&s_ready. In the following cycle wen=1, addr=cnt, value=s_data, and cnt increments. Write latency is 1 cycle from the accepted beat. Gaps in s_valid give gaps in wen. When the beat with cnt==n-1 is accepted: go to COMMIT if n==CGES, otherwise go to FILL.
- FILL: one write per cycle, with no handshake. In the next cycle wen=1, addr=cnt, value=0; cnt increments. When cnt==CGES-1, go to COMMIT.
- COMMIT: lasts one cycle. In the next cycle cges[i]=1 for i<n, cges[i]=0 for i>=n, and cges[0]=1 always; done=1. Then go to IDLE. done is therefore high exactly one cycle after the final wen pulse.
- cges never changes except at commit or reset, so partial loads are never visible downstream.
- abort in LOAD or FILL: go to IDLE next cycle; no beat is accepted in the abort cycle; writes already issued stand; cges unchanged; no done. abort in IDLE or COMMIT is ignored, so COMMIT always completes.
- Address never exceeds CGES-1. cnt has no wrap-around because the terminal compare always leaves the state.

Decomposition:
- Package coeff_pkg: BITS/CGES defaults, ADDR_W/NUM_W localparams, and state enum typedef (IDLE, LOAD, FILL, COMMIT).
- A thermometer-mask function (n -> CGES-bit mask with bit 0 forced to 1) also lives in the package.
- Single module; no sub-module warranted.

Test Plan:
- Reset: hold reset_n=0, then release -> wen=0, done=0, busy=0, s_ready=0, cges=49'h1.
- Full load: start cycle 0, num_taps=49, s_valid held high with s_data=i+1 -> beats accepted cycles 1..49; wen cycles 2..50 with addr=i, value=i+1; done only at cycle 51; cges=49'h1_FFFF_FFFF_FFFF.
- Partial load: num_taps=3, data 32'hA, 32'hB, 32'hC back-to-back -> addr 0..2 get A/B/C (wen cycles 2..4); addr 3..48 get 0 (wen cycles 5..50); done at cycle 51; cges=49'h7; s_ready low from cycle 4.
- Bubbles: num_taps=2, s_valid high only on cycles 1 and 5 -> wen at cycles 2 and 6 only during LOAD; s_ready high throughout cycles 1..5.
- Illegal start: num_taps=0, then num_taps=50 -> err pulse one cycle after each start; busy stays 0; cges unchanged.
- Abort and mid-load reset: abort with s_valid=1 after 10 beats -> no 11th write, busy=0 next cycle, no done, cges keeps its prior value (49'h7). Repeat with reset_n pulsed low mid-FILL -> outputs go to reset values immediately, cges=49'h1.
